// File: rtl/mem_port_arbiter.sv
// Burst arbiter sharing one single-port RAM between the SPI packet path (ext) and the core datapath.
// Define ARB_ROUND_ROBIN_EN to break request ties toward the side not served last.
module mem_port_arbiter #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 8,
   parameter int RD_LATENCY = 1,
   parameter int MAX_BURST  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   output logic              mem_rden,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              sel_ext
);

   typedef enum logic [1:0] {IDLE, EXT, CORE, TURN} state_t;

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
   // Pipe stages still in flight next cycle; the last stage is the returning one.
   localparam logic [RD_LATENCY-1:0] FLIGHT_MASK = {RD_LATENCY{1'b1}} >> 1;

   state_t                state, state_d;
   logic [CNT_W-1:0]      beat_cnt;
   logic                  preempt, preempt_d;
   logic                  last_ext;
   logic                  tie_to_core;
   logic                  ext_acc, core_acc, last_beat;
   logic                  rd_ext;
   logic [RD_LATENCY-1:0] pipe_ext, pipe_core;
   logic                  sel_ext_d;
   logic [DATA_W-1:0]     ext_rdata_q, core_rdata_q;

   function automatic state_t pick(input logic e, input logic c, input logic to_core);
      if (e && c)
         return to_core ? CORE : EXT;
      else if (e)
         return EXT;
      else if (c)
         return CORE;
      else
         return IDLE;
   endfunction

`ifdef ARB_ROUND_ROBIN_EN
   assign tie_to_core = last_ext;
`else
   assign tie_to_core = 1'b0;
`endif

   assign ext_acc   = ext_req & ext_gnt;
   assign core_acc  = core_req & core_gnt;
   assign last_beat = (beat_cnt == LAST_BEAT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         preempt  <= 1'b0;
         last_ext <= 1'b0;
         beat_cnt <= '0;
      end else begin
         state   <= state_d;
         preempt <= preempt_d;
         if (state_d == EXT)
            last_ext <= 1'b1;
         else if (state_d == CORE)
            last_ext <= 1'b0;
         if (state_d != state)
            beat_cnt <= '0;
         else if (ext_acc || core_acc)
            beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      state_d   = state;
      preempt_d = preempt;
      unique case (state)
         IDLE: state_d = pick(ext_req, core_req, tie_to_core);
         EXT: begin
            if (!ext_req) begin
               state_d   = TURN;
               preempt_d = 1'b0;
            end else if (last_beat && core_req) begin
               state_d   = TURN;
               preempt_d = 1'b1;
            end
         end
         CORE: begin
            if (!core_req) begin
               state_d   = TURN;
               preempt_d = 1'b0;
            end else if (last_beat && ext_req) begin
               state_d   = TURN;
               preempt_d = 1'b1;
            end
         end
         TURN: begin
            preempt_d = 1'b0;
            // last_ext still names the side that just gave up the port
            if (preempt && (last_ext ? core_req : ext_req))
               state_d = last_ext ? CORE : EXT;
            else
               state_d = pick(ext_req, core_req, tie_to_core);
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ext_gnt  = (state == EXT);
      core_gnt = (state == CORE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_wren     <= 1'b0;
         mem_rden     <= 1'b0;
         rd_ext       <= 1'b0;
         pipe_ext     <= '0;
         pipe_core    <= '0;
         sel_ext      <= 1'b0;
         ext_rdata_q  <= '0;
         core_rdata_q <= '0;
      end else begin
         mem_wren <= ext_acc ? ext_we : (core_acc & core_we);
         mem_rden <= (ext_acc & ~ext_we) | (core_acc & ~core_we);
         rd_ext   <= ext_acc & ~ext_we;
         if (ext_acc) begin
            mem_addr  <= ext_addr;
            mem_wdata <= ext_wdata;
         end else if (core_acc) begin
            mem_addr  <= core_addr;
            mem_wdata <= core_wdata;
         end
         pipe_ext  <= (pipe_ext << 1) | RD_LATENCY'(mem_rden & rd_ext);
         pipe_core <= (pipe_core << 1) | RD_LATENCY'(mem_rden & ~rd_ext);
         sel_ext   <= sel_ext_d;
         if (ext_rvalid)
            ext_rdata_q <= mem_rdata;
         if (core_rvalid)
            core_rdata_q <= mem_rdata;
      end
   end

   always_comb begin
      sel_ext_d = (state_d == EXT) | (ext_acc & ~ext_we) | (mem_rden & rd_ext)
                | (|(pipe_ext & FLIGHT_MASK));
   end

   assign ext_rvalid  = pipe_ext[RD_LATENCY-1];
   assign core_rvalid = pipe_core[RD_LATENCY-1];
   assign ext_rdata   = ext_rvalid ? mem_rdata : ext_rdata_q;
   assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with RD_LATENCY=2, MAX_BURST=4 and a 2-cycle RAM model.
module tb_mem_port_arbiter;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 8;
   localparam int RD_LAT = 2;
   localparam int MAXB   = 4;

   logic              clk, reset;
   logic              ext_req, ext_we, ext_gnt, ext_rvalid;
   logic [ADDR_W-1:0] ext_addr;
   logic [DATA_W-1:0] ext_wdata, ext_rdata;
   logic              core_req, core_we, core_gnt, core_rvalid;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata, core_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              mem_wren, mem_rden, sel_ext;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .MAX_BURST(MAXB)
   ) dut (
      .clk(clk), .reset(reset),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rden(mem_rden),
      .mem_rdata(mem_rdata), .sel_ext(sel_ext)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: data valid two cycles after the mem_rden cycle
   logic [DATA_W-1:0] ram [0:2047];
   logic [DATA_W-1:0] d1, d2;
   always @(posedge clk) begin
      if (reset) begin
         ram[11'h010] <= 8'h3C;
         ram[11'h020] <= 8'h5A;
         ram[11'h030] <= 8'hC3;
         ram[11'h040] <= 8'h96;
      end else if (mem_wren) begin
         ram[mem_addr] <= mem_wdata;
      end
      d1 <= mem_rden ? ram[mem_addr] : 8'h00;
      d2 <= d1;
   end
   assign mem_rdata = d2;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int                at;
   } mem_op_t;
   typedef struct {
      logic [DATA_W-1:0] data;
      int                at;
   } rd_exp_t;

   mem_op_t mem_q[$];
   rd_exp_t ext_q[$];
   rd_exp_t core_q[$];
   logic [DATA_W-1:0] ref_mem [0:2047];
   mem_op_t mop;
   rd_exp_t rop;

   // Monitor: compares DUT events against queued expectations, then queues new accepts
   initial begin
      ref_mem[11'h010] = 8'h3C;
      ref_mem[11'h020] = 8'h5A;
      ref_mem[11'h030] = 8'hC3;
      ref_mem[11'h040] = 8'h96;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (mem_wren || mem_rden) begin
               if (mem_q.size() == 0) begin
                  chk("mem_strobe_unexpected", 32'(1), 32'(0));
               end else begin
                  mop = mem_q.pop_front();
                  chk("mem_strobe_cycle", 32'(cyc), 32'(mop.at));
                  chk("mem_wren", 32'(mem_wren), 32'(mop.we));
                  chk("mem_rden", 32'(mem_rden), 32'(!mop.we));
                  chk("mem_addr", 32'(mem_addr), 32'(mop.addr));
                  if (mop.we) chk("mem_wdata", 32'(mem_wdata), 32'(mop.wdata));
               end
            end else if (mem_q.size() != 0 && mem_q[0].at <= cyc) begin
               chk("mem_strobe_missing", 32'(0), 32'(1));
               void'(mem_q.pop_front());
            end
            if (ext_rvalid) begin
               if (ext_q.size() == 0) begin
                  chk("ext_rvalid_unexpected", 32'(1), 32'(0));
               end else begin
                  rop = ext_q.pop_front();
                  chk("ext_rvalid_cycle", 32'(cyc), 32'(rop.at));
                  chk("ext_rdata", 32'(ext_rdata), 32'(rop.data));
               end
            end else if (ext_q.size() != 0 && ext_q[0].at <= cyc) begin
               chk("ext_rvalid_missing", 32'(0), 32'(1));
               void'(ext_q.pop_front());
            end
            if (core_rvalid) begin
               if (core_q.size() == 0) begin
                  chk("core_rvalid_unexpected", 32'(1), 32'(0));
               end else begin
                  rop = core_q.pop_front();
                  chk("core_rvalid_cycle", 32'(cyc), 32'(rop.at));
                  chk("core_rdata", 32'(core_rdata), 32'(rop.data));
               end
            end else if (core_q.size() != 0 && core_q[0].at <= cyc) begin
               chk("core_rvalid_missing", 32'(0), 32'(1));
               void'(core_q.pop_front());
            end
            if (ext_req && ext_gnt) begin
               mem_q.push_back('{ext_we, ext_addr, ext_wdata, cyc + 1});
               if (ext_we) ref_mem[ext_addr] = ext_wdata;
               else        ext_q.push_back('{ref_mem[ext_addr], cyc + 1 + RD_LAT});
            end
            if (core_req && core_gnt) begin
               mem_q.push_back('{core_we, core_addr, core_wdata, cyc + 1});
               if (core_we) ref_mem[core_addr] = core_wdata;
               else         core_q.push_back('{ref_mem[core_addr], cyc + 1 + RD_LAT});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      ext_req  = 1'b0;
      core_req = 1'b0;
      repeat (n) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [12:0] burst_e, burst_c;
   logic        tie2_ext, tie2_core;

   initial begin
      reset = 1'b1;
      ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
`ifdef ARB_ROUND_ROBIN_EN
      tie2_ext = 1'b0; tie2_core = 1'b1;
`else
      tie2_ext = 1'b1; tie2_core = 1'b0;
`endif
      burst_e = 13'h181E;
      burst_c = 13'h03C0;

      repeat (2) tick();
      chk("rst_ext_gnt", 32'(ext_gnt), 32'(0));
      chk("rst_core_gnt", 32'(core_gnt), 32'(0));
      chk("rst_mem_wren", 32'(mem_wren), 32'(0));
      chk("rst_mem_rden", 32'(mem_rden), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_sel_ext", 32'(sel_ext), 32'(0));
      chk("rst_ext_rvalid", 32'(ext_rvalid), 32'(0));
      chk("rst_core_rvalid", 32'(core_rvalid), 32'(0));
      chk("rst_ext_rdata", 32'(ext_rdata), 32'(0));
      chk("rst_core_rdata", 32'(core_rdata), 32'(0));
      reset = 1'b0;

      // single ext write
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = 11'h005; ext_wdata = 8'hA5;
      chk("wr_gnt_c0", 32'(ext_gnt), 32'(0));
      tick();
      chk("wr_gnt_c1", 32'(ext_gnt), 32'(1));
      chk("wr_wren_c1", 32'(mem_wren), 32'(0));
      tick();
      ext_req = 1'b0;
      chk("wr_wren_c2", 32'(mem_wren), 32'(1));
      chk("wr_addr_c2", 32'(mem_addr), 32'(11'h005));
      chk("wr_wdata_c2", 32'(mem_wdata), 32'(8'hA5));
      tick();
      chk("wr_turn_ext_gnt", 32'(ext_gnt), 32'(0));
      chk("wr_turn_core_gnt", 32'(core_gnt), 32'(0));
      chk("wr_wren_off", 32'(mem_wren), 32'(0));
      chk("wr_addr_hold", 32'(mem_addr), 32'(11'h005));
      idle(3);

      // core read, return 3 cycles after accept
      core_req = 1'b1; core_we = 1'b0; core_addr = 11'h010;
      tick();
      chk("rd_core_gnt", 32'(core_gnt), 32'(1));
      tick();
      core_req = 1'b0;
      chk("rd_rden", 32'(mem_rden), 32'(1));
      chk("rd_addr", 32'(mem_addr), 32'(11'h010));
      tick();
      chk("rd_rvalid_early", 32'(core_rvalid), 32'(0));
      tick();
      chk("rd_rvalid", 32'(core_rvalid), 32'(1));
      chk("rd_rdata", 32'(core_rdata), 32'(8'h3C));
      chk("rd_ext_rvalid", 32'(ext_rvalid), 32'(0));
      tick();
      chk("rd_rvalid_pulse", 32'(core_rvalid), 32'(0));
      chk("rd_rdata_hold", 32'(core_rdata), 32'(8'h3C));
      idle(3);

      // both requesting continuously: 4 ext, TURN, 4 core, TURN, ext
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = 11'h100; ext_wdata = 8'h11;
      core_req = 1'b1; core_we = 1'b1; core_addr = 11'h200; core_wdata = 8'h22;
      for (int i = 0; i < 13; i++) begin
         chk($sformatf("burst_ext_gnt[%0d]", i), 32'(ext_gnt), 32'(burst_e[i]));
         chk($sformatf("burst_core_gnt[%0d]", i), 32'(core_gnt), 32'(burst_c[i]));
         tick();
      end
      idle(4);

      // ext read, ext drops, core takes port as the read returns
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 11'h020;
      chk("hand_sel_c0", 32'(sel_ext), 32'(0));
      tick();
      core_req = 1'b1; core_we = 1'b0; core_addr = 11'h030;
      chk("hand_ext_gnt_c1", 32'(ext_gnt), 32'(1));
      chk("hand_sel_c1", 32'(sel_ext), 32'(1));
      tick();
      ext_req = 1'b0;
      chk("hand_sel_c2", 32'(sel_ext), 32'(1));
      tick();
      chk("hand_turn_ext", 32'(ext_gnt), 32'(0));
      chk("hand_turn_core", 32'(core_gnt), 32'(0));
      chk("hand_sel_c3", 32'(sel_ext), 32'(1));
      tick();
      chk("hand_core_gnt_c4", 32'(core_gnt), 32'(1));
      chk("hand_ext_rvalid_c4", 32'(ext_rvalid), 32'(1));
      chk("hand_ext_rdata_c4", 32'(ext_rdata), 32'(8'h5A));
      chk("hand_core_rvalid_c4", 32'(core_rvalid), 32'(0));
      chk("hand_sel_c4", 32'(sel_ext), 32'(1));
      tick();
      core_req = 1'b0;
      chk("hand_sel_c5", 32'(sel_ext), 32'(0));
      chk("hand_ext_rvalid_c5", 32'(ext_rvalid), 32'(0));
      tick();
      tick();
      chk("hand_core_rvalid_c7", 32'(core_rvalid), 32'(1));
      chk("hand_core_rdata_c7", 32'(core_rdata), 32'(8'hC3));
      idle(3);

      // reset mid-burst with two reads in flight
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 11'h040;
      tick();
      tick();
      tick();
      reset = 1'b1;
      ext_req = 1'b0;
      mem_q.delete();
      ext_q.delete();
      core_q.delete();
      #1;
      chk("mid_rst_ext_gnt", 32'(ext_gnt), 32'(0));
      chk("mid_rst_rden", 32'(mem_rden), 32'(0));
      chk("mid_rst_wren", 32'(mem_wren), 32'(0));
      chk("mid_rst_sel_ext", 32'(sel_ext), 32'(0));
      chk("mid_rst_ext_rvalid", 32'(ext_rvalid), 32'(0));
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("post_rst_ext_rvalid[%0d]", i), 32'(ext_rvalid), 32'(0));
         chk($sformatf("post_rst_ext_gnt[%0d]", i), 32'(ext_gnt), 32'(0));
         chk($sformatf("post_rst_core_gnt[%0d]", i), 32'(core_gnt), 32'(0));
         tick();
      end

      // two simultaneous first requests, released in between
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 11'h010;
      core_req = 1'b1; core_we = 1'b0; core_addr = 11'h010;
      tick();
      chk("tie1_ext_gnt", 32'(ext_gnt), 32'(1));
      chk("tie1_core_gnt", 32'(core_gnt), 32'(0));
      ext_req = 1'b0; core_req = 1'b0;
      tick();
      tick();
      ext_req = 1'b1; core_req = 1'b1;
      tick();
      chk("tie2_ext_gnt", 32'(ext_gnt), 32'(tie2_ext));
      chk("tie2_core_gnt", 32'(core_gnt), 32'(tie2_core));
      idle(8);

      chk("mem_q_drained", 32'(mem_q.size()), 32'(0));
      chk("ext_q_drained", 32'(ext_q.size()), 32'(0));
      chk("core_q_drained", 32'(core_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port on-chip memory (activation, parameter or instruction RAM) between two requesters.
- The external requester is the SPI packet path. The core requester is the processing datapath.
- Grants ownership in bursts, registers the memory-side strobes, and routes read data back to the requester that issued the read.
- Its ext-ownership flag replaces ad hoc external-select muxing at each memory.

Parameters:
ADDR_W, 11, memory address width
DATA_W, 8, memory data width
RD_LATENCY, 1, cycles from mem_rden to valid mem_rdata (1..4)
MAX_BURST, 16, max beats per grant when the other side is waiting (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
ext_req  in  1  external access request (level; held high for a burst)
ext_we  in  1  1=write, 0=read, sampled on accept
ext_addr  in  ADDR_W  external address
ext_wdata  in  DATA_W  external write data
ext_gnt  out  1  external owns port
ext_rvalid  out  1  ext_rdata valid (1-cycle pulse)
ext_rdata  out  DATA_W  read data to external
core_req, core_we, core_addr, core_wdata  in  1/1/ADDR_W/DATA_W  core request, same rules as ext_*
core_gnt, core_rvalid  out  1  core grant / read-data valid
core_rdata  out  DATA_W  read data to core
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wren  out  1  memory write strobe
mem_rden  out  1  memory read strobe
mem_rdata  in  DATA_W  memory read data
sel_ext  out  1  registered; 1 while ext owns port or has reads in flight

Behaviour:
- Reset (async, any time):
  - all outputs 0; state IDLE; beat counter 0; preempt flag 0; read tag pipeline cleared.
  - in-flight reads are dropped, so no rvalid is produced after reset.
- Accept: a beat is accepted in the cycle x_req & x_gnt.
  - On the next clk edge: mem_addr/mem_wdata take the accepted beat; mem_wren=we; mem_rden=!we.
  - In any cycle with no accept, mem_wren=mem_rden=0 and mem_addr/mem_wdata hold.
- Read return: a read accepted at cycle t gives x_rvalid=1 and x_rdata=mem_rdata at cycle t+1+RD_LATENCY.
  - The owner tag travels in a RD_LATENCY-deep shift register, so returns follow the issuing requester even after ownership changes.
  - x_rdata holds its last value when rvalid=0.
- FSM (registered gnt):
  - IDLE:
    - ext_req -> EXT (ext wins ties).
    - else core_req -> CORE.
  - EXT / CORE:
    - gnt of the owner = 1; beat_cnt increments per accepted beat.
    - Owner req=0 -> TURN, preempt=0.
    - Beat MAX_BURST accepted while the other req=1 -> TURN, preempt=1.
    - Beat MAX_BURST accepted while the other req=0 -> beat_cnt reloads to 0 and ownership stays.
  - TURN:
    - One cycle; both gnt=0; beat_cnt=0.
    - If preempt and the other req=1, go to the other side.
    - Else apply the IDLE priority rules.
    - If nobody requests, go to IDLE.
- Ownership change always costs exactly one dead cycle (TURN). Back-to-back beats from one owner run at 1 beat/cycle.
- Requester deasserting req while gnt=1 takes effect the next cycle. The beat in that cycle is not accepted.
- sel_ext = 1 in EXT, or while any ext-tagged read is in flight.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: in IDLE and non-preempt TURN, a tie goes to the requester not served last. A last_owner register is added; reset value = core, so ext wins the first tie.
- Undefined: fixed priority, ext over core, as above.

Test Plan:
- Reset, then ext_req=1, write addr 0x005 data 0xA5 -> ext_gnt=1 cycle 1; accepted cycle 1; mem_wren=1, mem_addr=0x005, mem_wdata=0xA5 cycle 2.
- Core read addr 0x010, RD_LATENCY=2, memory returns 0x3C -> core_rvalid=1, core_rdata=0x3C exactly 3 cycles after accept; ext_rvalid stays 0.
- Both requests held continuously, MAX_BURST=4 -> ext gets 4 beats, 1 TURN cycle, core gets 4 beats, TURN, ext again. Never 5 consecutive beats to one side.
- Ext issues a read, then drops req; core takes the port before that read returns -> ext_rvalid still fires on time; sel_ext high until it returns.
- Assert reset mid-burst with 2 reads in flight -> all gnt/strobes 0 immediately; no rvalid afterwards; IDLE after release.
- Simultaneous first requests after reset, twice (release both in between) -> fixed: ext/ext; with ARB_ROUND_ROBIN_EN: ext/core.
